// File: rtl/jt12_timer_pkg.sv
// Shared constants for the YM2612 Timer A/B block: default prescale ratios,
// counter widths and the register 0x27 bit layout.
package jt12_timer_pkg;

  localparam int TICK_DIV_DEF   = 24;
  localparam int B_PRESCALE_DEF = 16;
  localparam int TA_W           = 10;
  localparam int TB_W           = 8;

  // Register 0x27 bit positions
  localparam int REG27_LOAD_A = 0;
  localparam int REG27_LOAD_B = 1;
  localparam int REG27_EN_A   = 2;
  localparam int REG27_EN_B   = 3;
  localparam int REG27_CLR_A  = 4;
  localparam int REG27_CLR_B  = 5;

endpackage

// File: rtl/jt12_timer_cnt.sv
// One YM2612 timer counter: load-edge detect, up-count towards all-ones,
// reload on overflow. ovf is a combinational single-cycle overflow strobe.
module jt12_timer_cnt
  import jt12_timer_pkg::*;
#(
  parameter int CW = TA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          ovf
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          load_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          load_edge;

  assign load_edge = load & ~load_q;

  // Next count: a fresh load edge swallows a coincident tick; a stopped
  // timer (load low) neither counts nor overflows.
  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    if (load_edge) begin
      cnt_d = value;
    end else if (load && tick) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = value;
        ovf   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and load-history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      load_q <= load;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/jt12_timers_ab.sv
// YM2612 Timer A (10-bit) and Timer B (8-bit): shared prescalers, overflow
// flags, IRQ and the CSM key-on pulse.
// Build option: define JT12_CSM_EN to generate csm_pulse; otherwise it is 0.
module jt12_timers_ab
  import jt12_timer_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int B_PRESCALE = B_PRESCALE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [TA_W-1:0] value_a,
  input  logic [TB_W-1:0] value_b,
  input  logic            load_a,
  input  logic            load_b,
  input  logic            en_flag_a,
  input  logic            en_flag_b,
  input  logic            clr_flag_a,
  input  logic            clr_flag_b,
  output logic            flag_a,
  output logic            flag_b,
  output logic            irq_n,
  output logic            csm_pulse
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(B_PRESCALE);
  localparam logic [PW-1:0] PRES_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BPRES_LAST = BW'(B_PRESCALE - 1);

  logic [PW-1:0] pres_q, pres_d;
  logic [BW-1:0] bpres_q, bpres_d;
  logic          tick_a, tick_b;
  logic          ovf_a, ovf_b;
  logic          flag_a_q, flag_a_d;
  logic          flag_b_q, flag_b_d;

  assign tick_a = clk_en & (pres_q == PRES_LAST);
  assign tick_b = tick_a & (bpres_q == BPRES_LAST);

  // Prescaler next state: free-running, independent of the load bits
  always_comb begin
    pres_d  = pres_q;
    bpres_d = bpres_q;
    if (clk_en) begin
      pres_d = (pres_q == PRES_LAST) ? '0 : pres_q + 1'b1;
    end
    if (tick_a) begin
      bpres_d = (bpres_q == BPRES_LAST) ? '0 : bpres_q + 1'b1;
    end
  end

  // Prescaler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pres_q  <= '0;
      bpres_q <= '0;
    end else begin
      pres_q  <= pres_d;
      bpres_q <= bpres_d;
    end
  end

  jt12_timer_cnt #(.CW(TA_W)) u_cnt_a (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick_a),
    .load  (load_a),
    .value (value_a),
    .ovf   (ovf_a)
  );

  jt12_timer_cnt #(.CW(TB_W)) u_cnt_b (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick_b),
    .load  (load_b),
    .value (value_b),
    .ovf   (ovf_b)
  );

  // Flag next state: a set beats a coincident clear so no overflow is lost
  always_comb begin
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    if (ovf_a && en_flag_a) flag_a_d = 1'b1;
    else if (clr_flag_a)    flag_a_d = 1'b0;
    if (ovf_b && en_flag_b) flag_b_d = 1'b1;
    else if (clr_flag_b)    flag_b_d = 1'b0;
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
    end else begin
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
    end
  end

  assign flag_a = flag_a_q;
  assign flag_b = flag_b_q;
  assign irq_n  = ~(flag_a_q | flag_b_q);

`ifdef JT12_CSM_EN
  logic csm_q;

  // CSM key-on strobe on every Timer A overflow, aligned with flag updates
  always_ff @(posedge clk) begin
    if (rst) csm_q <= 1'b0;
    else     csm_q <= ovf_a;
  end

  assign csm_pulse = csm_q;
`else
  assign csm_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_timers_ab.sv
// Self-checking bench for jt12_timers_ab: a table of held-input phases with
// expected outputs, then a hand-written load-edge / stop / reload sequence.
module tb_jt12_timers_ab;
  import jt12_timer_pkg::*;

`ifdef JT12_CSM_EN
  localparam bit CSM_ON = 1'b1;
`else
  localparam bit CSM_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_en;
  logic [TA_W-1:0] value_a;
  logic [TB_W-1:0] value_b;
  logic            load_a, load_b, en_flag_a, en_flag_b, clr_flag_a, clr_flag_b;
  logic            flag_a, flag_b, irq_n, csm_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  jt12_timers_ab dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .value_a    (value_a),
    .value_b    (value_b),
    .load_a     (load_a),
    .load_b     (load_b),
    .en_flag_a  (en_flag_a),
    .en_flag_b  (en_flag_b),
    .clr_flag_a (clr_flag_a),
    .clr_flag_b (clr_flag_b),
    .flag_a     (flag_a),
    .flag_b     (flag_b),
    .irq_n      (irq_n),
    .csm_pulse  (csm_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string     name;
    bit        r;
    bit        ce;
    bit [7:0]  r27;
    bit [9:0]  va;
    bit [7:0]  vb;
    int        cycles;
    bit        fa;
    bit        fb;
    bit        irqn;
    bit        csm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, bit r, bit ce, bit [7:0] r27,
                              bit [9:0] va, bit [7:0] vb, int cyc,
                              bit fa, bit fb, bit irqn, bit csm);
    vec_t v;
    v.name = nm; v.r = r; v.ce = ce; v.r27 = r27; v.va = va; v.vb = vb;
    v.cycles = cyc; v.fa = fa; v.fb = fb; v.irqn = irqn; v.csm = csm;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(vec_t v);
    rst        = v.r;
    clk_en     = v.ce;
    value_a    = v.va;
    value_b    = v.vb;
    load_a     = v.r27[REG27_LOAD_A];
    load_b     = v.r27[REG27_LOAD_B];
    en_flag_a  = v.r27[REG27_EN_A];
    en_flag_b  = v.r27[REG27_EN_B];
    clr_flag_a = v.r27[REG27_CLR_A];
    clr_flag_b = v.r27[REG27_CLR_B];
  endtask

  initial begin
    bit saw;
    // Timer A, 1020: overflow every 96 clk_en edges after load at edge 1
    vecs.push_back(mk("rst0",       1, 0, 8'h00, 1020, 0,   2,   0, 0, 1, 0));
    vecs.push_back(mk("a_pre",      0, 1, 8'h05, 1020, 0,   95,  0, 0, 1, 0));
    vecs.push_back(mk("a_ovf1",     0, 1, 8'h05, 1020, 0,   1,   1, 0, 0, 1));
    vecs.push_back(mk("a_hold",     0, 1, 8'h05, 1020, 0,   1,   1, 0, 0, 0));
    vecs.push_back(mk("a_clr",      0, 1, 8'h15, 1020, 0,   1,   0, 0, 1, 0));
    vecs.push_back(mk("a_pre2",     0, 1, 8'h05, 1020, 0,   93,  0, 0, 1, 0));
    vecs.push_back(mk("a_ovf2",     0, 1, 8'h05, 1020, 0,   1,   1, 0, 0, 1));
    vecs.push_back(mk("a_clrrun",   0, 1, 8'h15, 1020, 0,   95,  0, 0, 1, 0));
    vecs.push_back(mk("a_setwins",  0, 1, 8'h15, 1020, 0,   1,   1, 0, 0, 1));
    vecs.push_back(mk("a_lone_clr", 0, 1, 8'h15, 1020, 0,   1,   0, 0, 1, 0));
    // Timer B, 254: overflow after 768 edges; A runs with its flag disabled
    vecs.push_back(mk("rst1",       1, 1, 8'h00, 1020, 254, 2,   0, 0, 1, 0));
    vecs.push_back(mk("b_pre",      0, 1, 8'h0B, 1020, 254, 767, 0, 0, 1, 0));
    vecs.push_back(mk("b_ovf",      0, 1, 8'h0B, 1020, 254, 1,   0, 1, 0, 1));
    // Reset mid-run with flag_b set, then restart from scratch
    vecs.push_back(mk("rst_mid",    1, 1, 8'h0F, 1020, 254, 1,   0, 0, 1, 0));
    vecs.push_back(mk("rst_pre",    0, 1, 8'h0F, 1020, 254, 95,  0, 0, 1, 0));
    vecs.push_back(mk("rst_ovf",    0, 1, 8'h0F, 1020, 254, 1,   1, 0, 0, 1));
    // value_a = max: every tick_a overflows, flag disabled
    vecs.push_back(mk("csm_rst",    1, 1, 8'h00, 1023, 0,   1,   0, 0, 1, 0));
    vecs.push_back(mk("csm_1",      0, 1, 8'h01, 1023, 0,   24,  0, 0, 1, 1));
    vecs.push_back(mk("csm_gap",    0, 1, 8'h01, 1023, 0,   1,   0, 0, 1, 0));
    vecs.push_back(mk("csm_2",      0, 1, 8'h01, 1023, 0,   23,  0, 0, 1, 1));

    apply(vecs[0]);
    foreach (vecs[i]) begin
      apply(vecs[i]);
      repeat (vecs[i].cycles) step();
      check({vecs[i].name, ".flag_a"}, 32'(flag_a), 32'(vecs[i].fa));
      check({vecs[i].name, ".flag_b"}, 32'(flag_b), 32'(vecs[i].fb));
      check({vecs[i].name, ".irq_n"},  32'(irq_n),  32'(vecs[i].irqn));
      check({vecs[i].name, ".csm"},    32'(csm_pulse), 32'(CSM_ON & vecs[i].csm));
      if (vecs[i].r) begin
        check({vecs[i].name, ".cnt_a"}, 32'(dut.u_cnt_a.cnt_q), 0);
        check({vecs[i].name, ".cnt_b"}, 32'(dut.u_cnt_b.cnt_q), 0);
      end
    end

    // Load edge landing on a tick_a cycle: the tick is swallowed
    rst = 1; clk_en = 1; load_a = 0; load_b = 0; en_flag_a = 1; en_flag_b = 0;
    clr_flag_a = 0; clr_flag_b = 0; value_a = 10'd1020; value_b = 8'd0;
    step();
    rst = 0;
    repeat (23) step();
    load_a = 1;
    step();
    check("edge_vs_tick.cnt_a", 32'(dut.u_cnt_a.cnt_q), 1020);
    value_a = 10'd1010;
    repeat (24) step();
    check("count_inc.cnt_a", 32'(dut.u_cnt_a.cnt_q), 1021);

    // Stopped timer holds and never overflows
    load_a = 0;
    saw = 1'b0;
    for (int k = 0; k < 96; k++) begin
      step();
      if (flag_a || csm_pulse || !irq_n) saw = 1'b1;
    end
    check("stop_hold.cnt_a", 32'(dut.u_cnt_a.cnt_q), 1021);
    check("stop_hold.no_ovf", 32'(saw), 0);

    // Restart reloads the value written while running
    load_a = 1;
    step();
    check("reload_new.cnt_a", 32'(dut.u_cnt_a.cnt_q), 1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
